plps_bram_bridge: RTL
=====================

Name: plps_bram_bridge

Overview:
- Parametrised PS-to-PL memory bridge that sits inside the plps board layer, between the PS register/command bus and NCH PL block RAMs (waveform, command and init BRAMs).
- Replaces the fixed one-BRAM-per-port wiring with a single decoded request port, a per-channel BRAM interface, configurable read latency and an out-of-range error report.
- One transaction in flight at a time; busy/done handshake to the PS side.

Parameters:
- NCH, 4, number of BRAM channels, 1..16.
- AW, 12, channel-local word address width.
- DW, 32, data width; must be a multiple of 8.
- RDLAT, 2, BRAM read latency in cycles, 1..7.

Ports:
- clk  in  1  single clock for bus and BRAMs.
- rst  in  1  asynchronous, active-high reset.
- wr_req  in  1  write request, sampled only when busy=0.
- rd_req  in  1  read request, sampled only when busy=0.
- addr  in  AW+4  bits [AW+3:AW] select the channel; bits [AW-1:0] are the word address.
- wdata  in  DW  write data.
- busy  out  1  high from the cycle after accept until the done cycle, inclusive.
- done  out  1  one-cycle completion pulse for both reads and writes.
- rvalid  out  1  one-cycle pulse, coincident with done, for reads only.
- rdata  out  DW  read data; held until the next read completes.
- err  out  1  one-cycle pulse with done when the selected channel is >= NCH.
- bram_en  out  NCH  per-channel enable.
- bram_we  out  NCH  per-channel write enable; widened under the option.
- bram_addr  out  NCH*AW  per-channel address, channel k at [k*AW +: AW].
- bram_din  out  NCH*DW  per-channel write data.
- bram_dout  in  NCH*DW  per-channel read data.

Behaviour:
- Reset: clk and rst are fixed as one clock with an asynchronous, active-high reset. All outputs go to 0 and the FSM to IDLE. Asserting rst mid-transaction aborts it: no done pulse, no retry, rdata cleared.
- Accept: at the edge where busy=0 and (wr_req or rd_req), the bridge latches addr, wdata and the op.
  - If both wr_req and rd_req are set, the write wins and the read is dropped.
  - Requests seen while busy=1 are ignored, not queued.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE -> ACCESS on accept.
- ACCESS, 1 cycle:
  - Selected channel drives bram_en=1, its address, and bram_din=wdata.
  - bram_we=1 for writes only.
  - All other channels drive en=0 and we=0.
  - An out-of-range channel drives no enable on any channel.
  - Write -> DONE. Read -> WAIT, with the counter loaded to RDLAT-1.
- WAIT: counts down. When the counter is 0, capture the selected channel's bram_dout into rdata and go to DONE.
  - An out-of-range read captures all zeros.
- DONE, 1 cycle: done=1, plus rvalid=1 for reads and err=1 if out of range. Then IDLE; busy=0 in the following cycle.
- Latency, counted from the accept edge to the done-high cycle:
  - Write: 2 cycles.
  - Read: RDLAT+2 cycles.
  - Back-to-back accept is possible the cycle after done falls, giving a throughput of one write per 3 cycles.
- Unselected-channel outputs: bram_addr and bram_din hold their last values; only en and we are gated.
- Out-of-range write: nothing is written, err pulses, and rdata is unchanged.

Optional Feature:
- Macro: PLPS_BRAM_BYTE_EN.
- Defined:
  - Adds input wstrb (DW/8 bits), latched at accept.
  - bram_we widens to NCH*DW/8; channel k at [k*DW/8 +: DW/8] equals wstrb during ACCESS of a write.
  - A write with wstrb=0 still produces done but no BRAM we bits.
- Undefined:
  - No wstrb port.
  - bram_we is NCH bits, whole-word writes only.

Test Plan:
- Reset then idle: rst=1 for 3 cycles then released -> all outputs 0, busy=0, no bram_en activity.
- Write, NCH=4, addr={4'd2,12'h010}, wdata=0xCAFEF00D:
  - Cycle+1: bram_en=4'b0100, bram_we=4'b0100, channel 2 addr=0x010, din=0xCAFEF00D.
  - Cycle+2: done=1, err=0.
- Read back with RDLAT=2, same address, BRAM model returns the stored word -> done=rvalid=1 at cycle+4, rdata=0xCAFEF00D.
- Out-of-range: wr_req to channel 7 with NCH=4 -> no bram_en at all, done=err=1 at cycle+2.
  - rd_req to channel 5 -> rdata=0, rvalid=err=1 at cycle+4.
- Contention and abort:
  - wr_req and rd_req together -> only the write occurs; a new request pulsed while busy=1 is ignored (exactly one done).
  - rst asserted during WAIT -> no done, rdata=0, IDLE after release.
- PLPS_BRAM_BYTE_EN defined, wstrb=4'b0011, channel 1 -> bram_we[7:4]=4'b0011, all other we bits 0. A write with wstrb=0 -> done=1, no we bits.

Source files
------------

// File: rtl/plps_bram_bridge.sv
// PS-to-PL bridge: one decoded request port fanned out to NCH block-RAM channels.
// Define PLPS_BRAM_BYTE_EN to add wstrb and widen bram_we to per-byte enables.
module plps_bram_bridge #(
    parameter int NCH   = 4,
    parameter int AW    = 12,
    parameter int DW    = 32,
    parameter int RDLAT = 2,
`ifdef PLPS_BRAM_BYTE_EN
    localparam int BW   = DW/8
`else
    localparam int BW   = 1
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [AW+3:0]     addr,
    input  logic [DW-1:0]     wdata,
`ifdef PLPS_BRAM_BYTE_EN
    input  logic [DW/8-1:0]   wstrb,
`endif
    output logic              busy,
    output logic              done,
    output logic              rvalid,
    output logic [DW-1:0]     rdata,
    output logic              err,
    output logic [NCH-1:0]    bram_en,
    output logic [NCH*BW-1:0] bram_we,
    output logic [NCH*AW-1:0] bram_addr,
    output logic [NCH*DW-1:0] bram_din,
    input  logic [NCH*DW-1:0] bram_dout
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    logic                r_wr;
    logic [3:0]          r_ch;
    logic [2:0]          r_cnt;
    logic                r_busy, r_done, r_rvalid, r_err;
    logic [DW-1:0]       r_rdata;
    logic [NCH-1:0]      r_en;
    logic [NCH*BW-1:0]   r_we;
    logic [NCH*AW-1:0]   r_addr;
    logic [NCH*DW-1:0]   r_din;

    logic [BW-1:0]       w_acc_we;
    logic                w_inr;
    logic [DW-1:0]       w_dout [16];

`ifdef PLPS_BRAM_BYTE_EN
    assign w_acc_we = wr_req ? wstrb : '0;
`else
    assign w_acc_we = wr_req;
`endif

    assign w_inr = (5'(r_ch) < 5'(NCH));

    // Channels beyond NCH read as zero so an out-of-range read captures all zeros.
    for (genvar g = 0; g < 16; g++) begin : g_dout
        if (g < NCH) begin : g_live
            assign w_dout[g] = bram_dout[g*DW +: DW];
        end else begin : g_dead
            assign w_dout[g] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wr     <= 1'b0;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_en     <= '0;
            r_we     <= '0;
            r_addr   <= '0;
            r_din    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wr_req || rd_req) begin
                        r_state <= S_ACCESS;
                        r_busy  <= 1'b1;
                        r_wr    <= wr_req;
                        r_ch    <= addr[AW+3:AW];
                        // Strobes are registered here so they are live exactly during ACCESS.
                        for (int k = 0; k < NCH; k++) begin
                            if (addr[AW+3:AW] == 4'(k)) begin
                                r_en[k]             <= 1'b1;
                                r_we[k*BW +: BW]    <= w_acc_we;
                                r_addr[k*AW +: AW]  <= addr[AW-1:0];
                                r_din[k*DW +: DW]   <= wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    r_en <= '0;
                    r_we <= '0;
                    if (r_wr) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= !w_inr;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= 3'(RDLAT-1);
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata  <= w_dout[r_ch];
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_rvalid <= 1'b1;
                        r_err    <= !w_inr;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_rvalid <= 1'b0;
                    r_err    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign bram_en   = r_en;
    assign bram_we   = r_we;
    assign bram_addr = r_addr;
    assign bram_din  = r_din;

endmodule
